// File: rtl/junction_dose_pkg.sv
// Shared types and helpers for the two-inlet junction dose sequencer:
// state encoding, per-state valve pattern and skip-aware next-state selection.
package junction_dose_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEAD    = 3'd1,
    ST_DOSE    = 3'd2,
    ST_TAIL    = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_COLLECT = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Valve pattern is {soln1, soln2, out}
  localparam logic [2:0] VP_CLOSED  = 3'b000;
  localparam logic [2:0] VP_LEAD    = 3'b010;
  localparam logic [2:0] VP_DOSE    = 3'b110;
  localparam logic [2:0] VP_TAIL    = 3'b100;
  localparam logic [2:0] VP_COLLECT = 3'b001;

  function automatic logic [2:0] valve_pattern(input state_e s);
    logic [2:0] vp;
    case (s)
      ST_LEAD:    vp = VP_LEAD;
      ST_DOSE:    vp = VP_DOSE;
      ST_TAIL:    vp = VP_TAIL;
      ST_COLLECT: vp = VP_COLLECT;
      default:    vp = VP_CLOSED;
    endcase
    return vp;
  endfunction

  // nz = {lag!=0, dose!=0, settle!=0, collect!=0}; DONE always has length 1
  function automatic logic state_nonzero(input state_e s, input logic [3:0] nz);
    logic r;
    case (s)
      ST_LEAD, ST_TAIL: r = nz[3];
      ST_DOSE:          r = nz[2];
      ST_SETTLE:        r = nz[1];
      ST_COLLECT:       r = nz[0];
      ST_DONE:          r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic state_e next_state(input state_e cur, input logic [3:0] nz);
    state_e nxt;
    logic   found;
    nxt   = ST_DONE;
    found = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (!found && (3'(i) > 3'(cur)) && state_nonzero(state_e'(3'(i)), nz)) begin
        nxt   = state_e'(3'(i));
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/junction_dose_sequencer_dwell_timer.sv
// Down-counting dwell timer: loads N-1 on state entry, saturates at zero.
module dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  // Dwell counter; holds at zero so it can never wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/junction_dose_sequencer.sv
// Junction dose sequencer: soln2 leads and trails soln1 by a lag so both
// fronts meet at the mixer, then settle, collect through the outlet, done.
module junction_dose_sequencer
  import junction_dose_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_lag,
  input  logic [CNT_W-1:0] cfg_dose,
  input  logic [CNT_W-1:0] cfg_settle,
  input  logic [CNT_W-1:0] cfg_collect,
  output logic             valve_soln1,
  output logic             valve_soln2,
  output logic             valve_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d, tgt_s;
  logic [CNT_W-1:0] lag_q, dose_q, settle_q, collect_q;
  logic [CNT_W-1:0] lag_d, dose_d, settle_d, collect_d;
  logic             err_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_expired;
  logic [3:0]       nz_q, nz_in;

  assign nz_q  = {(lag_q != '0), (dose_q != '0), (settle_q != '0), (collect_q != '0)};
  assign nz_in = {(cfg_lag != '0), (cfg_dose != '0), (cfg_settle != '0), (cfg_collect != '0)};

  function automatic logic [CNT_W-1:0] state_len(
    input state_e s, input logic [CNT_W-1:0] lag, input logic [CNT_W-1:0] dose,
    input logic [CNT_W-1:0] settle, input logic [CNT_W-1:0] collect);
    logic [CNT_W-1:0] n;
    case (s)
      ST_LEAD, ST_TAIL: n = lag;
      ST_DOSE:          n = dose;
      ST_SETTLE:        n = settle;
      ST_COLLECT:       n = collect;
      ST_DONE:          n = CNT_W'(1);
      default:          n = '0;
    endcase
    return n;
  endfunction

  // Next-state, config latch and timer reload decision
  always_comb begin
    state_d    = state_q;
    tgt_s      = ST_IDLE;
    lag_d      = lag_q;
    dose_d     = dose_q;
    settle_d   = settle_q;
    collect_d  = collect_q;
    err_d      = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_dose != '0) begin
            lag_d      = cfg_lag;
            dose_d     = cfg_dose;
            settle_d   = cfg_settle;
            collect_d  = cfg_collect;
            tgt_s      = next_state(ST_IDLE, nz_in);
            state_d    = tgt_s;
            timer_load = 1'b1;
            timer_val  = state_len(tgt_s, cfg_lag, cfg_dose, cfg_settle, cfg_collect) - CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEAD, ST_DOSE, ST_TAIL, ST_SETTLE, ST_COLLECT: begin
        if (abort) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (timer_expired) begin
          tgt_s      = next_state(state_q, nz_q);
          state_d    = tgt_s;
          timer_load = 1'b1;
          timer_val  = state_len(tgt_s, lag_q, dose_q, settle_q, collect_q) - CNT_W'(1);
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched config and outputs decoded from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lag_q       <= '0;
      dose_q      <= '0;
      settle_q    <= '0;
      collect_q   <= '0;
      valve_soln1 <= 1'b0;
      valve_soln2 <= 1'b0;
      valve_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      lag_q       <= lag_d;
      dose_q      <= dose_d;
      settle_q    <= settle_d;
      collect_q   <= collect_d;
      {valve_soln1, valve_soln2, valve_out} <= valve_pattern(state_d);
      busy        <= (state_d != ST_IDLE);
      done        <= (state_d == ST_DONE);
      err         <= err_d;
    end
  end

  dwell_timer #(.CNT_W(CNT_W)) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .enable   (state_q != ST_IDLE),
    .expired  (timer_expired)
  );

endmodule

// File: tb/tb_junction_dose_sequencer.sv
// Directed bench for junction_dose_sequencer: table of run scenarios with
// hand-computed valve windows, plus abort/reject/reset corner sequences.
module tb_junction_dose_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] cfg_lag, cfg_dose, cfg_settle, cfg_collect;
  logic        valve_soln1, valve_soln2, valve_out, busy, done, err;
  logic [5:0]  obs;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [15:0] l, d, s, c;
    int          s2_lo, s2_hi, s1_lo, s1_hi, out_lo, out_hi, done_c;
  } scen_t;

  scen_t tbl[6];

  always #5 clk = ~clk;

  assign obs = {valve_soln1, valve_soln2, valve_out, busy, done, err};

  junction_dose_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_lag(cfg_lag), .cfg_dose(cfg_dose), .cfg_settle(cfg_settle), .cfg_collect(cfg_collect),
    .valve_soln1(valve_soln1), .valve_soln2(valve_soln2), .valve_out(valve_out),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input int cyc, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: s1/s2/out/busy/done/err got %b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic logic [5:0] expect_at(input scen_t sc, input int c);
    logic s1, s2, o, b, d;
    s1 = (c >= sc.s1_lo) && (c <= sc.s1_hi);
    s2 = (c >= sc.s2_lo) && (c <= sc.s2_hi);
    o  = (c >= sc.out_lo) && (c <= sc.out_hi);
    b  = (c >= 1) && (c <= sc.done_c);
    d  = (c == sc.done_c);
    return {s1, s2, o, b, d, 1'b0};
  endfunction

  // Called at a negedge with the DUT idle; start is sampled at the next edge (cycle 0)
  task automatic run_scen(input scen_t sc, input bit disturb);
    cfg_lag = sc.l; cfg_dose = sc.d; cfg_settle = sc.s; cfg_collect = sc.c;
    chk({sc.name, "_idle"}, 0, obs, 6'b000000);
    start = 1'b1;
    for (int c = 1; c <= sc.done_c + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk(sc.name, c, obs, expect_at(sc, c));
      if (disturb && c <= 17) begin
        start       = 1'b1;
        cfg_lag     = 16'($urandom);
        cfg_dose    = 16'($urandom);
        cfg_settle  = 16'($urandom);
        cfg_collect = 16'($urandom);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"basic",   16'd3, 16'd5, 16'd2, 16'd4, 1, 8, 4, 11, 14, 17, 18};
    tbl[1] = '{"nolag",   16'd0, 16'd2, 16'd0, 16'd0, 1, 2, 1, 2,  1,  0,  3};
    tbl[2] = '{"ones",    16'd1, 16'd1, 16'd1, 16'd1, 1, 2, 2, 3,  5,  5,  6};
    tbl[3] = '{"nosettle",16'd2, 16'd3, 16'd0, 16'd2, 1, 5, 3, 7,  8,  9, 10};
    tbl[4] = '{"settleonly",16'd0, 16'd1, 16'd3, 16'd0, 1, 1, 1, 1, 1, 0,  5};
    tbl[5] = '{"maxdose", 16'd0, 16'hFFFF, 16'd0, 16'd0, 1, 65535, 1, 65535, 1, 0, 65536};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_lag = 16'd0; cfg_dose = 16'd0; cfg_settle = 16'd0; cfg_collect = 16'd0;
    repeat (2) @(negedge clk);
    chk("reset_hold", 0, obs, 6'b000000);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release", 0, obs, 6'b000000);

    for (int i = 0; i < 6; i++) run_scen(tbl[i], 1'b0);

    // start and cfg churn during a run must not alter the timing
    run_scen(tbl[0], 1'b1);

    // dose==0 rejected: err pulse only
    cfg_lag = 16'd3; cfg_dose = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("reject_err", 1, obs, 6'b000001);
    @(negedge clk);
    chk("reject_after", 2, obs, 6'b000000);

    // abort and start together in IDLE: nothing happens
    cfg_dose = 16'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("idle_abort_start", 1, obs, 6'b000000);
    @(negedge clk);
    chk("idle_abort_start2", 2, obs, 6'b000000);

    // abort in cycle 6 of the basic run, then a fresh start in cycle 8
    cfg_lag = 16'd3; cfg_dose = 16'd5; cfg_settle = 16'd2; cfg_collect = 16'd4;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 6)      chk("abort_run", c, obs, expect_at(tbl[0], c));
      else if (c == 7) chk("abort_err", c, obs, 6'b000001);
      else             chk("abort_idle", c, obs, 6'b000000);
      abort = (c == 6);
    end
    run_scen(tbl[0], 1'b0);

    // abort in the DONE cycle: done already pulsed, no err
    cfg_lag = 16'd0; cfg_dose = 16'd1; cfg_settle = 16'd0; cfg_collect = 16'd0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("dabort_dose", 1, obs, 6'b110100);
    @(negedge clk);
    chk("dabort_done", 2, obs, 6'b000110);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("dabort_after", 3, obs, 6'b000000);
    @(negedge clk);
    chk("dabort_after2", 4, obs, 6'b000000);

    // asynchronous reset mid-DOSE
    cfg_lag = 16'd3; cfg_dose = 16'd5; cfg_settle = 16'd2; cfg_collect = 16'd4;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("arst_run", c, obs, expect_at(tbl[0], c));
    end
    #2 rst = 1'b1;
    #1 chk("arst_immediate", 5, obs, 6'b000000);
    @(negedge clk);
    chk("arst_held", 6, obs, 6'b000000);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_released", 7, obs, 6'b000000);
    run_scen(tbl[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/junction_dose_sequencer.md
Name: junction_dose_sequencer

Overview:
- Sequencer for the two-inlet serpentine/diffusion-mixer junction.
- Drives the soln1 and soln2 inlet valves and the outlet valve.
- The soln2 branch is the long serpentine chain and the soln1 branch is short. The block opens soln2 early and closes it early by a programmable lag, so both fluid fronts and both tails reach the mixer together.
- After dosing it waits a settle time, opens the outlet for a collect window, then reports done. Sits between the host run controller and the valve driver stage.

Parameters:
- CNT_W, 16, width of every duration field and of the dwell counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  stops the current run; closes all valves.
- cfg_lag  input  CNT_W  soln2 lead/lead-out time in cycles; 0 allowed.
- cfg_dose  input  CNT_W  dual-open dose time in cycles; must be nonzero.
- cfg_settle  input  CNT_W  all-closed mixing time in cycles; 0 allowed.
- cfg_collect  input  CNT_W  outlet-open time in cycles; 0 allowed.
- valve_soln1  output  1  soln1 inlet valve open.
- valve_soln2  output  1  soln2 inlet valve open.
- valve_out  output  1  outlet valve open.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a run completes.
- err  output  1  one-cycle pulse on a rejected start or an abort.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, latched configuration 0. Reset mid-run closes all valves immediately (asynchronous).
- All outputs are registered and decoded from the state register. No combinational path exists from any input to any output.
- States: IDLE, LEAD, DOSE, TAIL, SETTLE, COLLECT, DONE.
- Valve pattern per state (soln1/soln2/out):
  - LEAD 0/1/0
  - DOSE 1/1/0
  - TAIL 1/0/0
  - SETTLE, COLLECT, DONE, IDLE: all 0 except COLLECT 0/0/1.
- Start:
  - start=1 in IDLE with cfg_dose!=0: latch all cfg_* fields in the same edge, then enter the first nonzero-length state in the order LEAD, DOSE.
  - start=1 in IDLE with cfg_dose==0: err pulses the next cycle; state stays IDLE.
  - start while busy: ignored.
  - cfg_* changes during a run have no effect.
- Dwell timing:
  - On entry to a state of length N, the counter loads N-1. It decrements each cycle; the state exits when counter==0.
  - Each timed state therefore lasts exactly N cycles.
  - A state whose latched length is 0 is skipped entirely, with no one-cycle glitch on any valve.
- Durations and order:
  - LEAD and TAIL both last cfg_lag cycles. DOSE lasts cfg_dose, SETTLE lasts cfg_settle, COLLECT lasts cfg_collect.
  - Order: LEAD→DOSE→TAIL→SETTLE→COLLECT→DONE→IDLE.
  - DONE lasts 1 cycle and asserts done.
- Latency: with start sampled at edge 0, done is high in cycle 1+2L+D+S+C. busy falls the cycle after done.
- Totals: soln1 open-cycles = D+L; soln2 open-cycles = L+D (equal doses).
- Abort:
  - In any busy state, abort=1 → next cycle: all valves 0, err=1, state IDLE, no done.
  - Abort in IDLE: ignored.
  - Abort and start in the same IDLE cycle: start is ignored and err stays 0.
  - Abort in the DONE cycle: done still pulses (run already complete), err stays 0.
- The counter never wraps. The maximum length 2^CNT_W-1 is legal.

Decomposition:
- Package junction_dose_pkg:
  - state enum (3-bit encoding: IDLE=0, LEAD, DOSE, TAIL, SETTLE, COLLECT, DONE);
  - per-state valve-pattern constant (3-bit {soln1,soln2,out});
  - a function returning the next nonzero-length state from a given state and the latched lengths.
- One sub-module, dwell_timer:
  - inputs: load, load_val, enable;
  - output: expired (counter==0);
  - CNT_W parameterised; same clk/rst.

Test Plan:
- L=3, D=5, S=2, C=4, start pulse at cycle 0:
  - soln2 high cycles 1–8; soln1 high cycles 4–11; out high cycles 14–17;
  - done in cycle 18; busy 1–18.
- L=0, D=2, S=0, C=0: soln1 and soln2 both high cycles 1–2 with no glitch on out; done in cycle 3.
- cfg_dose=0 with start: err pulse in cycle 1; busy and all valves stay 0.
- Abort asserted in cycle 6 of the first scenario: all valves 0 and err=1 in cycle 7; done never asserts; a new start in cycle 8 runs normally.
- start re-asserted during a run, and cfg_* changed mid-run: timing is identical to the first scenario.
- rst asserted mid-DOSE, asynchronously between edges: valves drop without waiting for a clock edge; after release, IDLE with all outputs 0.
